// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scanout block.
// Holds the default 640x480@60 timing set, the colour field widths,
// the fixed border colour and the line-fetch state encoding.
package vga_pkg;

   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 29;

   localparam int R_W   = 3;
   localparam int G_W   = 3;
   localparam int B_W   = 2;
   localparam int RGB_W = R_W + G_W + B_W;

   localparam logic [RGB_W-1:0] FG_RGB_D   = 8'b000_111_00;
   localparam logic [RGB_W-1:0] BORDER_RGB = 8'b111_000_00;

   typedef enum logic [1:0] {
      F_IDLE,
      F_REQ,
      F_FULL
   } fetch_st_t;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with region and sync decode.
// Ports:
//   dclk, rst_n      pixel clock, async active-low reset
//   h_cnt, v_cnt     current raster position
//   h_last, v_last   position is the last pixel of a line / last line of a frame
//   vis              position is inside the visible window
//   hs_on, vs_on     position is inside the h / v sync pulse
// All decode outputs are combinational from the counters; the caller registers them.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW      = $clog2(H_TOTAL),
   localparam int VW      = $clog2(V_TOTAL)
) (
   input  logic          dclk,
   input  logic          rst_n,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output logic          h_last,
   output logic          v_last,
   output logic          vis,
   output logic          hs_on,
   output logic          vs_on
);

   assign h_last = (h_cnt == HW'(H_TOTAL - 1));
   assign v_last = (v_cnt == VW'(V_TOTAL - 1));

   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   assign vis   = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
   assign hs_on = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_on = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_scanout.sv
// 1-bpp line-buffered VGA scanout.
// Fetches the next visible line during horizontal blanking into a back
// buffer, swaps it to the front buffer at end of line, and paints lit
// pixels in FG_RGB. A fetch still pending at end of line is abandoned,
// pulses underrun and blanks the following line.
// Ports:
//   dclk, rst_n             pixel clock, async active-low reset
//   line_req, line_addr     fetch request and requested visible line index
//   line_ack, line_data     fetch completion strobe and 1-bpp line (bit i = x i)
//   hsync, vsync, de        registered syncs and data enable
//   red, grn, blu           registered pixel colour
//   frame_start, underrun   registered one-cycle status pulses
// Optional: define VGA_SCANOUT_BORDER_EN to paint a frame border in BORDER_RGB.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int               H_ACTIVE = H_ACTIVE_D,
   parameter int               H_FP     = H_FP_D,
   parameter int               H_SYNC   = H_SYNC_D,
   parameter int               H_BP     = H_BP_D,
   parameter int               V_ACTIVE = V_ACTIVE_D,
   parameter int               V_FP     = V_FP_D,
   parameter int               V_SYNC   = V_SYNC_D,
   parameter int               V_BP     = V_BP_D,
   parameter logic             SYNC_POL = 1'b0,
   parameter logic [RGB_W-1:0] FG_RGB   = FG_RGB_D,
   parameter int               LINE_AW  = 9
) (
   input  logic                dclk,
   input  logic                rst_n,
   output logic                line_req,
   output logic [LINE_AW-1:0]  line_addr,
   input  logic                line_ack,
   input  logic [H_ACTIVE-1:0] line_data,
   output logic                hsync,
   output logic                vsync,
   output logic [R_W-1:0]      red,
   output logic [G_W-1:0]      grn,
   output logic [B_W-1:0]      blu,
   output logic                de,
   output logic                frame_start,
   output logic                underrun
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int XW      = $clog2(H_ACTIVE);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_last, v_last, vis, hs_on, vs_on;

   vga_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .dclk   (dclk),
      .rst_n  (rst_n),
      .h_cnt  (h_cnt),
      .v_cnt  (v_cnt),
      .h_last (h_last),
      .v_last (v_last),
      .vis    (vis),
      .hs_on  (hs_on),
      .vs_on  (vs_on)
   );

   fetch_st_t         st, st_nxt;
   logic [H_ACTIVE-1:0] back_buf, front_buf;
   logic              line_ok;
   logic [VW-1:0]     nxt_line;
   logic              nxt_vis;
   logic              cap_back, ld_from_back, ld_from_data, set_ok, clr_ok, ld_addr, miss;
   logic [RGB_W-1:0]  pix_rgb;

   assign nxt_line = v_last ? '0 : v_cnt + 1'b1;
   assign nxt_vis  = (nxt_line < VW'(V_ACTIVE));
   assign line_req = (st == F_REQ);

   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= F_IDLE;
         line_addr <= '0;
         line_ok   <= 1'b0;
      end else begin
         st <= st_nxt;
         if (ld_addr) line_addr <= nxt_line[LINE_AW-1:0];
         if (set_ok)      line_ok <= 1'b1;
         else if (clr_ok) line_ok <= 1'b0;
      end
   end

   always_comb begin
      st_nxt       = st;
      cap_back     = 1'b0;
      ld_from_back = 1'b0;
      ld_from_data = 1'b0;
      set_ok       = 1'b0;
      clr_ok       = 1'b0;
      ld_addr      = 1'b0;
      miss         = 1'b0;
      case (st)
         F_IDLE: begin
            // Nothing fetched for the coming line: show it blank.
            if (h_last) clr_ok = 1'b1;
            if (h_cnt == HW'(H_ACTIVE) && nxt_vis) begin
               st_nxt  = F_REQ;
               ld_addr = 1'b1;
            end
         end
         F_REQ: begin
            if (h_last) begin
               st_nxt = F_IDLE;
               if (line_ack) begin
                  // Last-moment ack: data goes straight to the front buffer.
                  ld_from_data = 1'b1;
                  set_ok       = 1'b1;
               end else begin
                  miss   = 1'b1;
                  clr_ok = 1'b1;
               end
            end else if (line_ack) begin
               cap_back = 1'b1;
               st_nxt   = F_FULL;
            end
         end
         F_FULL: begin
            if (h_last) begin
               ld_from_back = 1'b1;
               set_ok       = 1'b1;
               st_nxt       = F_IDLE;
            end
         end
         default: st_nxt = F_IDLE;
      endcase
   end

   // Line buffers are pure data; validity is tracked by line_ok.
   always_ff @(posedge dclk) begin
      if (cap_back) back_buf <= line_data;
      if (ld_from_back)      front_buf <= back_buf;
      else if (ld_from_data) front_buf <= line_data;
   end

   always_comb begin
      pix_rgb = '0;
      if (vis && line_ok && front_buf[h_cnt[XW-1:0]]) pix_rgb = FG_RGB;
`ifdef VGA_SCANOUT_BORDER_EN
      if (vis && (h_cnt == '0 || h_cnt == HW'(H_ACTIVE - 1) ||
                  v_cnt == '0 || v_cnt == VW'(V_ACTIVE - 1)))
         pix_rgb = BORDER_RGB;
`endif
   end

   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         de          <= 1'b0;
         red         <= '0;
         grn         <= '0;
         blu         <= '0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
         vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
         de          <= vis;
         {red, grn, blu} <= pix_rgb;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         underrun    <= miss;
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a reduced raster (16+2+3+3 x 6+1+2+1)
// so several whole frames fit in a short run. Expected pixel outputs are
// derived from raster position and the ack behaviour chosen per step.
module tb_vga_scanout;

   localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
   localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;

   logic          dclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          line_req;
   logic [2:0]    line_addr;
   logic          line_ack = 1'b0;
   logic [HA-1:0] line_data = '0;
   logic          hsync, vsync, de, frame_start, underrun;
   logic [2:0]    red, grn;
   logic [1:0]    blu;

   vga_scanout #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_POL(1'b0), .FG_RGB(8'h1C), .LINE_AW(3)
   ) dut (
      .dclk(dclk), .rst_n(rst_n),
      .line_req(line_req), .line_addr(line_addr),
      .line_ack(line_ack), .line_data(line_data),
      .hsync(hsync), .vsync(vsync),
      .red(red), .grn(grn), .blu(blu),
      .de(de), .frame_start(frame_start), .underrun(underrun)
   );

   always #20 dclk = ~dclk;

   int total = 0;
   int bad   = 0;
   int cnt   = 0;   // posedges since reset release
   int age   = 0;   // cycles line_req has been seen high
   bit ack_en;
   int ack_dly;
   int skip_line;
   bit uniq;

   localparam logic [15:0] RST_VEC = {3'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

   function automatic logic [15:0] pat(int n);
      logic [15:0] p;
      p = 16'h5555;
      if (uniq) p = p ^ (16'h0003 << (2 * n));
      return p;
   endfunction

   function automatic bit missed(int n);
      return !ack_en || (n == skip_line);
   endfunction

   function automatic logic [15:0] obs_vec();
      return {3'b0, de, hsync, vsync, frame_start, underrun, red, grn, blu};
   endfunction

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_pix();
      int p, h, v, f, n;
      bit vis, on, de_e, hs_e, vs_e, fs_e, uf_e;
      logic [7:0]  rgb_e;
      logic [15:0] pd;
      p = cnt - 1;
      h = p % HT;
      v = (p / HT) % VT;
      f = p / (HT * VT);
      n = (v + 1) % VT;
      vis  = (h < HA) && (v < VA);
      on   = !(f == 0 && v == 0) && !missed(v);
      pd   = pat(v);
      de_e = vis;
      hs_e = !(h >= HA + HFP && h < HA + HFP + HS);
      vs_e = !(v >= VA + VFP && v < VA + VFP + VS);
      fs_e = (h == 0) && (v == 0);
      uf_e = (h == HT - 1) && (n < VA) && missed(n);
      rgb_e = 8'h00;
`ifdef VGA_SCANOUT_BORDER_EN
      if (vis && (h == 0 || h == HA - 1 || v == 0 || v == VA - 1)) rgb_e = 8'hE0;
      else
`endif
      if (vis && on && pd[h]) rgb_e = 8'h1C;
      chk($sformatf("pix f%0d x%0d y%0d", f, h, v), obs_vec(),
          {3'b0, de_e, hs_e, vs_e, fs_e, uf_e, rgb_e});
   endtask

   task automatic respond();
      int n;
      bit skip;
      if (line_req) begin
         age++;
         n = ((cnt / HT) % VT + 1) % VT;
         skip = (n == skip_line);
         chk($sformatf("line_addr c%0d", cnt), 16'(line_addr), 16'(n));
         if (ack_en && !skip && age == ack_dly + 1) begin
            line_ack  = 1'b1;
            line_data = pat(n);
         end else begin
            line_ack = 1'b0;
            if (ack_en && !skip && age > ack_dly + 1)
               chk($sformatf("req_drop c%0d", cnt), 16'(line_req), 16'd0);
         end
      end else begin
         age      = 0;
         line_ack = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge dclk);
      cnt++;
      @(negedge dclk);
      check_pix();
      respond();
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      line_ack  = 1'b0;
      line_data = '0;
      repeat (2) @(negedge dclk);
      chk("rst_out",  obs_vec(), RST_VEC);
      chk("rst_req",  16'(line_req), 16'd0);
      chk("rst_addr", 16'(line_addr), 16'd0);
      cnt   = 0;
      age   = 0;
      rst_n = 1'b1;
   endtask

   initial begin
      // No acks: every visible-line fetch misses, screen stays dark.
      ack_en = 1'b0; ack_dly = 3; skip_line = -1; uniq = 1'b0;
      do_reset();
      run(2 * HT * VT + 4);

      // Ack 3 cycles after each request, alternating pixels.
      ack_en = 1'b1;
      do_reset();
      run(2 * HT * VT + 4);

      // Line 3 fetch withheld; per-line patterns expose buffer mixups.
      uniq = 1'b1; skip_line = 3;
      do_reset();
      run(HT * VT + 2 * HT);

      // Ack arriving on the last pixel of the line.
      skip_line = -1; ack_dly = 6;
      do_reset();
      run(HT * VT + 2 * HT);

      // Reset in the middle of an outstanding fetch.
      ack_dly = 3; uniq = 1'b0;
      do_reset();
      for (int i = 0; i < 100 && !line_req; i++) step();
      chk("req_seen", 16'(line_req), 16'd1);
      #5 rst_n = 1'b0;
      #1;
      chk("rst_mid_out",  obs_vec(), RST_VEC);
      chk("rst_mid_req",  16'(line_req), 16'd0);
      chk("rst_mid_addr", 16'(line_addr), 16'd0);
      do_reset();
      run(HT * VT + HT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
